shift_acc_mult_seq: RTL and testbench
=====================================

// Module: shift_acc_mult_seq
// PURPOSE
//   Signed two's-complement multiplier built on the shift-and-accumulate algorithm.
//   Registered output: the product of the operands sampled at each rising clock edge
//   appears on result after that edge.
//   Used wherever a full-width 32x32 signed product is needed with one-cycle latency.
// PARAMETERS
//   WIDTH  32  operand width in bits; result is 2*WIDTH bits
// PORTS
//   clk     in   1        clock, rising-edge active
//   reset   in   1        asynchronous, active-low reset (0 = reset asserted)
//   A       in   WIDTH    multiplicand, signed two's complement
//   B       in   WIDTH    multiplier, signed two's complement
//   result  out  2*WIDTH  signed product A*B, registered
// BEHAVIOUR
//   - Clocking: one clock (clk). Reset is asynchronous and active-low.
//   - Reset: while reset==0, result is forced to 0 immediately, independent of clk.
//     The first product is captured on the first rising edge after reset returns to 1.
//   - Product capture: on each rising clk edge with reset==1,
//     result <= signed(A) * signed(B), full 2*WIDTH-bit exact product.
//   - Latency and throughput:
//     - Latency is exactly 1 cycle: operands present at edge N give their product
//       on result after edge N.
//     - One new operand pair is accepted every cycle.
//     - No handshake, no start/done, no back-pressure.
//   - Algorithm (combinational datapath in front of the result register):
//     - Start from acc = 0 (2*WIDTH bits).
//     - For i = 0..WIDTH-2: if B[i]==1, acc += sext(A) << i.
//     - For i = WIDTH-1 (sign bit of B): if B[i]==1, acc -= sext(A) << i.
//     - sext() extends A to 2*WIDTH bits. All additions are modulo 2^(2*WIDTH).
//     - The datapath is an unrolled chain of WIDTH add/sub stages (one per bit of B).
//       No behavioural '*' operator.
//   - Width rules:
//     - The product of two WIDTH-bit signed values always fits in 2*WIDTH bits,
//       so no overflow can occur.
//     - result is the exact signed product, sign-extended to the full width.
//   - Boundary cases:
//     - A==0 or B==0 gives result 0.
//     - B==1 gives sext(A). B==-1 gives -sext(A).
//     - A==B==-2^(WIDTH-1) gives +2^(2*WIDTH-2); for WIDTH=32 this is 0x4000_0000_0000_0000.
//     - A==-2^(WIDTH-1), B==1 gives 0xFFFF_FFFF_8000_0000 (WIDTH=32).
//   - Operand changes: operands may change every cycle. Only values stable around
//     the rising edge (setup/hold) are used; changes between edges do not affect
//     result until the next edge.
//   - Reset mid-stream: asserting reset clears result at once. No partial state
//     survives, because the datapath holds no state other than result.
// TESTING
//   1. Mixed signs: A=50, B=-40 -> result=-2000 (0xFFFF_FFFF_FFFF_F830) one cycle later.
//   2. Signs:
//      - A=90, B=70 -> 6300.
//      - A=-80, B=-65 -> 5200.
//      - A=-10, B=325 -> -3250.
//   3. Identity/zero:
//      - A=98756, B=0 -> 0.
//      - A=98765, B=1 -> 98765.
//      - A=-500, B=2000 -> -1000000.
//      - A=-999, B=999 -> -998001.
//   4. Extremes:
//      - A=B=0x8000_0000 -> 0x4000_0000_0000_0000.
//      - A=0x7FFF_FFFF, B=0x7FFF_FFFF -> 0x3FFF_FFFF_0000_0001.
//      - A=0x8000_0000, B=0x7FFF_FFFF -> 0xC000_0000_8000_0000.
//   5. Back-to-back: new operands every cycle. Each result matches the pair sampled
//      on the previous edge, with no gaps.
//   6. Reset:
//      - Drive reset=0 mid-stream -> result=0 immediately, without waiting for clk.
//      - Release reset -> the next edge loads the current A*B.

Source files
------------

// File: rtl/shift_acc_mult_seq.sv
// shift_acc_mult_seq
//   Signed two's-complement multiplier with one cycle of latency. It does not
//   use a '*' operator. An unrolled chain of WIDTH add/sub stages computes
//   A*B combinationally. Each stage covers one bit of B. The full 2*WIDTH-bit
//   product is registered on every rising edge of clk.
//
// Ports
//   clk     in   1        clock, rising-edge active
//   reset   in   1        asynchronous reset, active-low (0 clears result)
//   A       in   WIDTH    multiplicand, signed
//   B       in   WIDTH    multiplier, signed
//   result  out  2*WIDTH  registered signed product A*B
module shift_acc_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     A,
  input  logic signed [WIDTH-1:0]     B,
  output logic signed [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;

  // Stage p0: combinational shift-and-accumulate chain
  logic signed [PW-1:0] a_ext_p0;
  logic signed [PW-1:0] acc_p0 [0:WIDTH];

  assign a_ext_p0  = {{WIDTH{A[WIDTH-1]}}, A};
  assign acc_p0[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic signed [PW-1:0] term_p0;
    assign term_p0 = a_ext_p0 << i;
    if (i < WIDTH - 1) begin : g_add
      assign acc_p0[i+1] = B[i] ? (acc_p0[i] + term_p0) : acc_p0[i];
    end else begin : g_sub
      // B's MSB has weight -2^(WIDTH-1), so this stage subtracts.
      assign acc_p0[i+1] = B[i] ? (acc_p0[i] - term_p0) : acc_p0[i];
    end
  end

  // Stage p1: product register
  logic signed [PW-1:0] prod_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_p1 <= '0;
    end else begin
      prod_p1 <= acc_p0[WIDTH];
    end
  end

  assign result = prod_p1;

endmodule

// File: tb/tb_shift_acc_mult_seq.sv
module tb_shift_acc_mult_seq;

  logic               clk;
  logic               reset;
  logic signed [31:0] A;
  logic signed [31:0] B;
  logic signed [63:0] result;

  int checks   = 0;
  int failures = 0;

  logic signed [63:0] sb_q [$];

  shift_acc_mult_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam int NV = 14;
  localparam logic signed [31:0] TA [NV] = '{
    32'sd50, 32'sd90, -32'sd80, -32'sd10, 32'sd98756, 32'sd98765, -32'sd500,
    -32'sd999, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
    32'sd1234, 32'sd0};
  localparam logic signed [31:0] TB [NV] = '{
    -32'sd40, 32'sd70, -32'sd65, 32'sd325, 32'sd0, 32'sd1, 32'sd2000,
    32'sd999, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'sd1,
    -32'sd1, -32'sd7};
  localparam logic signed [63:0] TE [NV] = '{
    -64'sd2000, 64'sd6300, 64'sd5200, -64'sd3250, 64'sd0, 64'sd98765,
    -64'sd1000000, -64'sd998001, 64'h4000_0000_0000_0000,
    64'h3FFF_FFFF_0000_0001, 64'hC000_0000_8000_0000,
    64'hFFFF_FFFF_8000_0000, -64'sd1234, 64'sd0};

  function automatic logic signed [63:0] model(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    longint la, lb;
    la = longint'(a);
    lb = longint'(b);
    return la * lb;
  endfunction

  task automatic test_reset();
    logic signed [63:0] exp;
    reset = 1'b0;
    A = 32'sd123;
    B = -32'sd456;
    #2;
    checks++;
    if (result !== 64'sd0) begin
      failures++;
      $display("FAIL reset_initial: result=%0h expected=0", result);
    end
    @(posedge clk); #1;
    checks++;
    if (result !== 64'sd0) begin
      failures++;
      $display("FAIL reset_hold_edge: result=%0h expected=0", result);
    end
    @(negedge clk);
    reset = 1'b1;
    sb_q.push_back(model(A, B));
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL reset_first_capture: result=%0d expected=%0d", result, exp);
    end
  endtask

  task automatic test_vectors();
    logic signed [63:0] exp;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      A = TA[i];
      B = TB[i];
      sb_q.push_back(TE[i]);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if (result !== exp) begin
        failures++;
        $display("FAIL vector_%0d: A=%0d B=%0d result=%0h expected=%0h",
                 i, TA[i], TB[i], result, exp);
      end
    end
  endtask

  task automatic test_operand_hold();
    logic signed [63:0] exp;
    @(negedge clk);
    A = 32'sd777;
    B = -32'sd3;
    sb_q.push_back(-64'sd2331);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL hold_capture: result=%0d expected=%0d", result, exp);
    end
    #1;
    A = 32'sd1000;
    B = 32'sd1000;
    #2;
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL hold_between_edges: result=%0d expected=%0d", result, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [63:0] exp;
    logic signed [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      if (i % 8 == 3) a = -a;
      A = a;
      B = b;
      sb_q.push_back(model(a, b));
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      checks++;
      if (result !== exp) begin
        failures++;
        $display("FAIL back_to_back_%0d: A=%0h B=%0h result=%0h expected=%0h",
                 i, a, b, result, exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic signed [63:0] exp;
    @(negedge clk);
    A = 32'sd1234;
    B = 32'sd5678;
    sb_q.push_back(64'sd7006652);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL midstream_pre: result=%0d expected=%0d", result, exp);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (result !== 64'sd0) begin
      failures++;
      $display("FAIL midstream_async_clear: result=%0h expected=0", result);
    end
    @(negedge clk);
    A = 32'sd55;
    B = 32'sd66;
    @(posedge clk); #1;
    checks++;
    if (result !== 64'sd0) begin
      failures++;
      $display("FAIL midstream_held: result=%0h expected=0", result);
    end
    @(negedge clk);
    A = -32'sd7;
    B = 32'sd9;
    reset = 1'b1;
    sb_q.push_back(-64'sd63);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    checks++;
    if (result !== exp) begin
      failures++;
      $display("FAIL midstream_release: result=%0d expected=%0d", result, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    A = '0;
    B = '0;
    test_reset();
    test_vectors();
    test_operand_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
